// File: rtl/solver_scheduler.sv
// Round-robin scheduler sharing one linear_solver among N requesters.
// Operands and results pass through untouched as double bit patterns.
module solver_scheduler #(
    parameter int N           = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*1024-1:0]   req_ops,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        rsp_valid,
    input  logic                rsp_ack,
    output logic [63:0]         rsp_c1,
    output logic [63:0]         rsp_c2,
    output logic [63:0]         rsp_c3,
    output logic                rsp_err,
    output logic                busy,
    output logic                slv_en,
    output logic [1023:0]       slv_ops,
    input  logic                slv_done,
    input  logic [63:0]         slv_c1,
    input  logic [63:0]         slv_c2,
    input  logic [63:0]         slv_c3,
    output logic [CNT_W-1:0]    solve_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, RESP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, rr_ptr, pick;
    logic [IW:0]   cand;
    logic          found;
    logic [TW-1:0] tcnt;
    logic          done_q, done_rise, tmo;

    assign done_rise = slv_done & ~done_q;
    assign tmo       = (tcnt == TW'(TIMEOUT_CYC - 1));

    // First asserted request at or after rr_ptr, wrapping modulo N
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N))
                cand = cand - (IW+1)'(N);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN: begin
                if (done_rise)
                    state_nxt = CAPTURE;
                else if (tmo)
                    state_nxt = RESP;
            end
            CAPTURE: state_nxt = RESP;
            RESP:    if (rsp_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        busy      = (state != IDLE);
        slv_en    = (state == RUN);
        if (state == LOAD)
            gnt[idx] = 1'b1;
        if (state == RESP)
            rsp_valid[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            rr_ptr    <= '0;
            tcnt      <= '0;
            done_q    <= 1'b0;
            slv_ops   <= '0;
            rsp_c1    <= '0;
            rsp_c2    <= '0;
            rsp_c3    <= '0;
            rsp_err   <= 1'b0;
            solve_cnt <= '0;
        end else begin
            done_q <= slv_done;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        idx     <= pick;
                        slv_ops <= req_ops[pick*1024 +: 1024];
                    end
                end
                LOAD: tcnt <= '0;
                RUN: begin
                    tcnt <= tcnt + 1'b1;
                    // A done edge in the last cycle still counts as success
                    if (!done_rise && tmo) begin
                        rsp_err <= 1'b1;
                        rsp_c1  <= '0;
                        rsp_c2  <= '0;
                        rsp_c3  <= '0;
                    end
                end
                CAPTURE: begin
                    rsp_c1    <= slv_c1;
                    rsp_c2    <= slv_c2;
                    rsp_c3    <= slv_c3;
                    rsp_err   <= 1'b0;
                    solve_cnt <= solve_cnt + 1'b1;
                end
                RESP: begin
                    if (rsp_ack)
                        rr_ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_solver_scheduler.sv
// Randomized bench for solver_scheduler with a behavioural solver
// and a rule-level model of arbitration, latency and results.
module tb_solver_scheduler;

    localparam int N   = 3;
    localparam int TMO = 64;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*1024-1:0] req_ops;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic              rsp_ack;
    logic [63:0]       rsp_c1, rsp_c2, rsp_c3;
    logic              rsp_err;
    logic              busy;
    logic              slv_en;
    logic [1023:0]     slv_ops;
    logic              slv_done;
    logic [63:0]       slv_c1, slv_c2, slv_c3;
    logic [CW-1:0]     solve_cnt;

    int total = 0;
    int bad   = 0;
    int ptr   = 0;
    int exp_cnt = 0;

    int   d_cfg = 0;
    logic force_done = 1'b0;
    int   en_cnt = 0;

    always #5 clk = ~clk;

    solver_scheduler #(.N(N), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ops(req_ops),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_c1(rsp_c1), .rsp_c2(rsp_c2), .rsp_c3(rsp_c3),
        .rsp_err(rsp_err), .busy(busy), .slv_en(slv_en),
        .slv_ops(slv_ops), .slv_done(slv_done),
        .slv_c1(slv_c1), .slv_c2(slv_c2), .slv_c3(slv_c3),
        .solve_cnt(solve_cnt)
    );

    // Solver model: done pulses in the d_cfg-th enabled cycle (0 = never)
    always @(posedge clk) begin
        if (!slv_en) en_cnt <= 0;
        else         en_cnt <= en_cnt + 1;
    end
    assign slv_done = force_done |
                      (d_cfg > 0 && slv_en && en_cnt == d_cfg - 1);

    function automatic int pick_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    function automatic logic [N*1024-1:0] rand_ops();
        logic [N*1024-1:0] v;
        for (int i = 0; i < N*32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_txn(input logic [N-1:0] r,
                          input logic [N*1024-1:0] ops,
                          input logic [63:0] c1, input logic [63:0] c2,
                          input logic [63:0] c3, input int d,
                          input int ackdly, input int hold, input bit drop);
        int e, c, lat, exp_lat;
        bit cap;
        logic [N-1:0] eg;
        logic [1023:0] eops;
        logic [191:0] ec;
        req_ops = ops;
        slv_c1 = c1; slv_c2 = c2; slv_c3 = c3;
        d_cfg = d;
        force_done = (hold > 0);
        req = r;
        e = pick_model(r, ptr);
        eg = '0; eg[e] = 1'b1;
        eops = ops[e*1024 +: 1024];
        c = 0;
        do begin @(negedge clk); c++; end while (gnt === '0 && c < 10);
        total++;
        if (gnt !== eg || c != 1) begin
            bad++;
            $display("FAIL grant got=%b exp=%b wait=%0d exp_wait=1", gnt, eg, c);
        end
        total++;
        if (slv_ops !== eops || slv_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load got_ops_lo=%h exp_ops_lo=%h en=%b busy=%b",
                     slv_ops[127:0], eops[127:0], slv_en, busy);
        end
        if (drop) req = '0;
        lat = 0;
        while (rsp_valid === '0 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == hold) force_done = 1'b0;
            if (lat == 1) begin
                total++;
                if (gnt !== '0 || slv_en !== 1'b1) begin
                    bad++;
                    $display("FAIL run_entry gnt=%b en=%b exp gnt=0 en=1", gnt, slv_en);
                end
            end
        end
        force_done = 1'b0;
        cap = (d >= 1) && (d <= TMO) && (d > hold);
        exp_lat = cap ? d + 2 : TMO + 1;
        ec = cap ? {c1, c2, c3} : '0;
        if (cap) exp_cnt = (exp_cnt + 1) % (1 << CW);
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL latency got=%0d exp=%0d", lat, exp_lat);
        end
        total++;
        if (rsp_valid !== eg || busy !== 1'b1 || slv_en !== 1'b0) begin
            bad++;
            $display("FAIL resp got=%b busy=%b en=%b exp=%b busy=1 en=0",
                     rsp_valid, busy, slv_en, eg);
        end
        total++;
        if (rsp_err !== !cap) begin
            bad++;
            $display("FAIL rsp_err got=%b exp=%b", rsp_err, !cap);
        end
        total++;
        if ({rsp_c1, rsp_c2, rsp_c3} !== ec) begin
            bad++;
            $display("FAIL rsp_c got=%h exp=%h", {rsp_c1, rsp_c2, rsp_c3}, ec);
        end
        total++;
        if (solve_cnt !== CW'(exp_cnt)) begin
            bad++;
            $display("FAIL solve_cnt got=%0d exp=%0d", solve_cnt, exp_cnt);
        end
        for (int i = 0; i < ackdly; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== eg || gnt !== '0 || busy !== 1'b1 ||
                {rsp_c1, rsp_c2, rsp_c3} !== ec || rsp_err !== !cap) begin
                bad++;
                $display("FAIL hold got v=%b g=%b b=%b c=%h exp v=%b g=0 b=1 c=%h",
                         rsp_valid, gnt, busy, {rsp_c1, rsp_c2, rsp_c3}, eg, ec);
            end
        end
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        total++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL after_ack got v=%b busy=%b exp v=0 busy=0", rsp_valid, busy);
        end
        ptr = (e + 1) % N;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== '0 || rsp_valid !== '0 || busy !== 1'b0 || slv_en !== 1'b0 ||
            rsp_err !== 1'b0 || solve_cnt !== '0) begin
            bad++;
            $display("FAIL reset_ctl g=%b v=%b b=%b en=%b err=%b cnt=%0d exp all 0",
                     gnt, rsp_valid, busy, slv_en, rsp_err, solve_cnt);
        end
        total++;
        if (slv_ops !== '0 || {rsp_c1, rsp_c2, rsp_c3} !== '0) begin
            bad++;
            $display("FAIL reset_data ops_lo=%h c=%h exp 0", slv_ops[127:0],
                     {rsp_c1, rsp_c2, rsp_c3});
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rsp_valid !== '0 || gnt !== '0) begin
            bad++;
            $display("FAIL idle_ack busy=%b v=%b g=%b exp 0", busy, rsp_valid, gnt);
        end
    endtask

    task automatic test_single();
        logic [N*1024-1:0] o;
        o = rand_ops();
        o[0 +: 1024] = '0;
        o[1*64 +: 64]  = 64'h4024000000000000;
        o[6*64 +: 64]  = 64'h4024000000000000;
        o[11*64 +: 64] = 64'h4024000000000000;
        for (int k = 12; k < 16; k++) o[k*64 +: 64] = 64'h4014000000000000;
        do_txn(3'b001, o, 64'h3FF0000000000000, 64'h4000000000000000,
               64'h4008000000000000, 15, 0, 0, 1'b0);
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++)
            do_txn(3'b011, rand_ops(), rand64(), rand64(), rand64(),
                   $urandom_range(3, 20), 1, 0, 1'b0);
        req = '0;
    endtask

    task automatic test_timeout();
        do_txn(3'b100, rand_ops(), rand64(), rand64(), rand64(), 0, 0, 0, 1'b0);
        do_txn(3'b100, rand_ops(), rand64(), rand64(), rand64(), TMO, 0, 0, 1'b0);
        do_txn(3'b100, rand_ops(), rand64(), rand64(), rand64(), TMO + 1, 2, 0, 1'b0);
        req = '0;
    endtask

    task automatic test_stale_done();
        do_txn(3'b010, rand_ops(), rand64(), rand64(), rand64(), 10, 0, 200, 1'b0);
        do_txn(3'b010, rand_ops(), rand64(), rand64(), rand64(), 10, 0, 5, 1'b0);
        do_txn(3'b010, rand_ops(), rand64(), rand64(), rand64(), 10, 0, 10, 1'b0);
        req = '0;
    endtask

    task automatic test_backpressure();
        do_txn(3'b101, rand_ops(), rand64(), rand64(), rand64(), 8, 20, 0, 1'b0);
        do_txn(3'b101, rand_ops(), rand64(), rand64(), rand64(), 8, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        int d, k;
        for (int i = 0; i < 25; i++) begin
            k = $urandom_range(0, 9);
            d = (k == 0) ? 0 : (k == 1) ? TMO + $urandom_range(0, 3) :
                $urandom_range(1, 40);
            do_txn(N'($urandom_range(1, (1 << N) - 1)), rand_ops(), rand64(),
                   rand64(), rand64(), d, $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0,
                   1'(($urandom_range(0, 1))));
        end
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        int c;
        do_txn(3'b001, rand_ops(), rand64(), rand64(), rand64(), 4, 0, 0, 1'b0);
        req_ops = rand_ops();
        d_cfg = 30;
        req = 3'b011;
        c = 0;
        do begin @(negedge clk); c++; end while (gnt === '0 && c < 10);
        total++;
        if (gnt !== 3'b010) begin
            bad++;
            $display("FAIL pre_reset_grant got=%b exp=010", gnt);
        end
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (slv_en !== 1'b0 || busy !== 1'b0 || gnt !== '0 || rsp_valid !== '0 ||
            solve_cnt !== '0 || slv_ops !== '0) begin
            bad++;
            $display("FAIL mid_reset en=%b b=%b g=%b v=%b cnt=%0d exp all 0",
                     slv_en, busy, gnt, rsp_valid, solve_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        exp_cnt = 0;
        do_txn(3'b011, rand_ops(), rand64(), rand64(), rand64(), 6, 0, 0, 1'b0);
        req = '0;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        req_ops = '0;
        rsp_ack = 1'b0;
        slv_c1 = '0; slv_c2 = '0; slv_c3 = '0;
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_stale_done();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/solver_scheduler.md
Name: solver_scheduler

Overview:
- Shares one linear_solver trilateration datapath between N requesters.
- Each requester supplies a full operand set: 4 anchor positions (x,y,z) and 4 ranges, as IEEE-754 double bit patterns.
- The block arbitrates round-robin, loads operands, drives solver enable, and detects completion or timeout.
- Returns c1..c3 to the granted requester over a valid/ack handshake. Sits between requester agents and the single solver instance.

Parameters:
- N, 2, number of requesters (2..8).
- TIMEOUT_CYC, 64, max cycles in RUN waiting for solver done before flagging error.
- CNT_W, 16, width of completed-solve counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester solve request, level
- req_ops  in  N*1024  per-requester operands. Slice i = bits [i*1024 +: 1024]. Within a slice, 64-bit words from LSB: x1,x2,x3,x4,y1..y4,z1..z4,r1..r4.
- gnt  out  N  one-hot, one-cycle pulse on grant
- rsp_valid  out  N  one-hot result valid, held until ack
- rsp_ack  in  1  consumer accepts the result
- rsp_c1, rsp_c2, rsp_c3  out  64 each  result coordinates (double bit patterns)
- rsp_err  out  1  result invalid (timeout); qualified by rsp_valid
- busy  out  1  high in any state other than IDLE
- slv_en  out  1  solver enable
- slv_ops  out  1024  registered operands to solver, same packing as req_ops
- slv_done  in  1  solver done
- slv_c1, slv_c2, slv_c3  in  64 each  solver results
- solve_cnt  out  CNT_W  count of successful (non-error) solves, wraps

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - gnt, rsp_valid, rsp_err, busy, slv_en = 0.
  - slv_ops, rsp_c*, solve_cnt = 0.
  - rr_ptr = 0; timeout counter = 0; done_q = 0.
  - Reset mid-solve aborts silently; no response is issued.
- States: IDLE, LOAD, RUN, CAPTURE, RESP.
- IDLE:
  - If req != 0, grant the first asserted req scanning from rr_ptr upward, modulo N.
  - In the same edge: latch idx, register req_ops[idx] into slv_ops, pulse gnt[idx] for one cycle, go to LOAD.
  - req is sampled only in IDLE; requests arriving during other states wait.
- LOAD: one cycle with slv_ops stable and slv_en = 0. Clear timeout counter. Go to RUN.
- RUN:
  - slv_en = 1 and timeout counter increments each cycle.
  - done_q is a register of slv_done. Completion is a rising edge: slv_done = 1 and done_q = 0. A done level held over from a previous solve is ignored.
  - On rising edge: go to CAPTURE.
  - Else, when the counter reaches TIMEOUT_CYC-1: go to RESP with rsp_err = 1 and rsp_c* = 0.
  - If a rising edge and the timeout coincide, the rising edge wins.
- CAPTURE:
  - Register slv_c1..c3 into rsp_c1..c3; rsp_err = 0; slv_en = 0.
  - Increment solve_cnt, wrapping at 2^CNT_W.
  - Go to RESP.
- RESP:
  - rsp_valid[idx] = 1 and rsp_c*/rsp_err are held stable until rsp_ack = 1.
  - On ack: rsp_valid is cleared, rr_ptr = (idx+1) mod N, go to IDLE.
  - An ack present in the same cycle RESP is entered counts, so the minimum RESP length is 1 cycle.
  - rsp_ack outside RESP is ignored.
- slv_en is 0 in every state except RUN. The solver's output registers are not read outside CAPTURE.
- Latency from grant to rsp_valid = 1 (LOAD) + solver cycles in RUN + 1 (CAPTURE).
- Requesters dropping req after gnt does not affect the in-flight solve.
- gnt never pulses twice without an intervening RESP.
- No arithmetic is performed on data: operands and results pass through as bit patterns.

Test Plan:
- Single request: req = 01 with anchors (0,0,0), (10,0,0), (0,10,0), (0,0,10) and solver model returning done after 15 cycles with c = (1.0,2.0,3.0) → gnt = 01 for 1 cycle; slv_ops matches slice 0; rsp_valid = 01 17 cycles after gnt; rsp_c1 = 64'h3FF0000000000000; rsp_err = 0; solve_cnt = 1.
- Contention with N=2: req = 11 held continuously, ack 1 cycle after each valid → grants alternate 01, 10, 01, 10; no requester is granted twice in a row.
- Timeout: solver model never asserts done, TIMEOUT_CYC = 64 → rsp_valid after 64 RUN cycles; rsp_err = 1; rsp_c* = 0; solve_cnt unchanged; slv_en falls.
- Stale done: slv_done held high from the previous solve entering RUN → no capture until done falls and rises again.
- Backpressure: rsp_ack withheld 20 cycles while the other req is pending → rsp_c* stable, no new gnt, busy = 1; grant follows ack by 1 cycle.
- Reset mid-RUN: rst pulsed at RUN cycle 5 → slv_en, busy, gnt, rsp_valid = 0 immediately; after release, a pending req is granted from rr_ptr = 0.
